prog_clk_divider: RTL and testbench
===================================

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 26, counter and divisor width in bits.
REQ-002 SHALL have parameter NCH, default 2, number of independent divider channels.
REQ-003 SHALL have parameter DEFAULT_DIV, default 24, divisor loaded at reset.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  NCH  per-channel count enable.
REQ-007 SHALL have port mode  input  NCH  per-channel output mode: 0 toggle, 1 pulse.
REQ-008 SHALL have port sync  input  1  restart all channels in phase.
REQ-009 SHALL have port cfg_valid  input  1  divisor write request.
REQ-010 SHALL have port cfg_ready  output  1  divisor write may be accepted.
REQ-011 SHALL have port cfg_ch  input  max(1,clog2(NCH))  target channel of write.
REQ-012 SHALL have port cfg_div  input  WIDTH  new divisor value.
REQ-013 SHALL have port clk_out  output  NCH  divided clock (mode 0) or strobe (mode 1), registered.
REQ-014 SHALL have port tick  output  NCH  one-cycle strobe at each terminal count, registered.
REQ-015 SHALL have port pending  output  NCH  shadow divisor waiting to be applied.

Function
REQ-016 Each channel SHALL hold count (WIDTH), div, shadow, tgl, tick, pending.
REQ-017 With en[i]=1 and count!=div: count SHALL increment by 1; tick SHALL be 0.
REQ-018 With en[i]=1 and count==div (terminal): count->0, tgl->~tgl, tick->1 for exactly one cycle.
REQ-019 Half-period SHALL be div+1 clk_in cycles; toggle-mode period 2*(div+1), 50% duty; div=0 gives period 2.
REQ-020 With en[i]=0: count, tgl hold; tick SHALL be 0.
REQ-021 clk_out[i] SHALL equal tgl when mode[i]=0 and tick when mode[i]=1; mode change affects only this mux, never count.
REQ-022 cfg_ready SHALL be ~pending[cfg_ch] combinationally; cfg_ch>=NCH SHALL give cfg_ready=1 and the write SHALL be discarded.
REQ-023 On cfg_valid&cfg_ready: shadow[cfg_ch]<-cfg_div, pending[cfg_ch]<-1 at that edge.
REQ-024 Pending divisor with en[i]=1 SHALL be applied at the next terminal edge: div<-shadow, pending<-0, count<-0; the current half-period completes with the old div.
REQ-025 Pending divisor with en[i]=0 SHALL be applied on the next edge, count<-0, tgl unchanged.
REQ-026 sync=1 SHALL, regardless of en, set every channel count<-0, tgl<-0, tick<-0 and apply any pending divisor; sync overrides terminal-count action that cycle.
REQ-027 count SHALL never exceed div (divisor changes only with count<-0); div=2^WIDTH-1 SHALL be legal.
REQ-028 Accept and apply SHALL never coincide on one channel (ready low while pending); writes to different channels are independent.

Reset
REQ-029 rst=1 SHALL set count=0, tgl=0, tick=0, pending=0, div=shadow=DEFAULT_DIV for all channels; clk_out=0, tick=0, pending=0, cfg_ready=1 next cycle.
REQ-030 rst SHALL override sync, cfg writes and enables, including mid-count and with writes pending.

Structure
REQ-031 Package clk_div_pkg SHALL hold MODE_TOGGLE=0, MODE_PULSE=1, default WIDTH and DEFAULT_DIV.
REQ-032 One sub-module clk_div_channel (count, div, shadow, tgl, tick, pending) SHALL be instantiated NCH times by generate; top holds cfg decode and cfg_ready mux.

Verification
REQ-033 rst then en=2'b11, mode=0, no cfg: clk_out[0] first rises 25 edges after reset release, period 50, high 25.
REQ-034 write ch1 div=3, mode[1]=1: tick[1]=clk_out[1] high 1 cycle in every 4.
REQ-035 ch0 running div=24, write div=4 at count=10: pending[0]=1, cfg_ready low for ch0, toggle at count 24, then half-periods of 5, pending cleared at that edge.
REQ-036 write div=0 on ch0: after apply clk_out[0] toggles every cycle (period 2).
REQ-037 both channels div=3 at different counts, pulse sync: both clk_out=0, then toggles aligned every 4 cycles.
REQ-038 rst mid-count with pending[1]=1: all outputs 0, pending 0, period restored to 50.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
package clk_div_pkg;
  localparam int DEF_WIDTH = 26;
  localparam int DEF_DIV = 24;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE = 1'b1;
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadowed divisor applied at count restart.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);
  logic [WIDTH-1:0] count_q, count_d, div_q, div_d, shadow_q, shadow_d;
  logic tgl_q, tgl_d, tick_q, tick_d, pending_q, pending_d;
  logic term, apply, wr;
  // The shadow divisor only lands when count restarts, so count never exceeds div.
  always_comb begin
    term = en_i && (count_q == div_q);
    apply = pending_q && (sync_i || !en_i || term);
    wr = wr_i && !pending_q;
    count_d = (sync_i || apply || term) ? '0 : count_q + WIDTH'(en_i);
    tgl_d = sync_i ? 1'b0 : tgl_q ^ term;
    tick_d = !sync_i && term;
    div_d = apply ? shadow_q : div_q;
    shadow_d = wr ? wdata_i : shadow_q;
    pending_d = wr || (pending_q && !apply);
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_q <= '0;
      div_q <= WIDTH'(DEFAULT_DIV);
      shadow_q <= WIDTH'(DEFAULT_DIV);
      tgl_q <= 1'b0;
      tick_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      tgl_q <= tgl_d;
      tick_q <= tick_d;
      pending_q <= pending_d;
    end
  end
  assign clk_out_o = (mode_i == MODE_TOGGLE) ? tgl_q : tick_q;
  assign tick_o = tick_q;
  assign pending_o = pending_q;
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: NCH independent programmable clock dividers with a shared config port.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = 2,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [NCH-1:0]            en,
  input  logic [NCH-1:0]            mode,
  input  logic                      sync,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_bits(NCH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]          cfg_div,
  output logic [NCH-1:0]            clk_out,
  output logic [NCH-1:0]            tick,
  output logic [NCH-1:0]            pending
);
  localparam int CW = ch_bits(NCH);
  localparam int PW = 1 << CW;
  logic [PW-1:0] pend_x;
  // Unused channel codes read as not-pending, so they look ready and the write falls on no channel.
  assign pend_x = PW'(pending);
  assign cfg_ready = ~pend_x[cfg_ch];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_channel #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .en_i     (en[i]),
      .mode_i   (mode[i]),
      .sync_i   (sync),
      .wr_i     (cfg_valid && cfg_ready && (cfg_ch == CW'(i))),
      .wdata_i  (cfg_div),
      .clk_out_o(clk_out[i]),
      .tick_o   (tick[i]),
      .pending_o(pending[i])
    );
  end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed scenarios plus random traffic against a countdown reference model.
module tb_prog_clk_divider;
  localparam int W = 26, N = 2, DD = 24;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic rst, sync, cfg_valid, cfg_ready;
  logic [N-1:0] en, mode, clk_out, tick, pending;
  logic [0:0] cfg_ch;
  logic [W-1:0] cfg_div;
  int total = 0, bad = 0;
  longint rem[N], dv[N], sh[N];
  bit ph[N], tk[N], pd[N];

  prog_clk_divider #(.WIDTH(W), .NCH(N), .DEFAULT_DIV(DD)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .mode(mode), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // rem counts edges left until the terminal edge; ph is the toggle phase.
  task automatic model();
    for (int i = 0; i < N; i++) begin
      bit acc;
      acc = cfg_valid && (cfg_ch == i) && !pd[i];
      if (rst) begin
        rem[i] = DD; dv[i] = DD; sh[i] = DD; ph[i] = 0; tk[i] = 0; pd[i] = 0;
      end else begin
        if (sync) begin
          ph[i] = 0; tk[i] = 0;
          if (pd[i]) begin dv[i] = sh[i]; pd[i] = 0; end
          rem[i] = dv[i];
        end else if (en[i]) begin
          if (rem[i] == 0) begin
            ph[i] = !ph[i]; tk[i] = 1;
            if (pd[i]) begin dv[i] = sh[i]; pd[i] = 0; end
            rem[i] = dv[i];
          end else begin
            rem[i]--; tk[i] = 0;
          end
        end else begin
          tk[i] = 0;
          if (pd[i]) begin dv[i] = sh[i]; pd[i] = 0; rem[i] = dv[i]; end
        end
        if (acc) begin sh[i] = cfg_div; pd[i] = 1; end
      end
    end
  endtask

  task automatic cycle();
    #1 check("cfg_ready", cfg_ready, !pd[cfg_ch]);
    @(posedge clk_in);
    model();
    @(negedge clk_in);
    for (int i = 0; i < N; i++) begin
      check($sformatf("clk_out%0d", i), clk_out[i], mode[i] ? tk[i] : ph[i]);
      check($sformatf("tick%0d", i), tick[i], tk[i]);
      check($sformatf("pending%0d", i), pending[i], pd[i]);
    end
  endtask

  task automatic write(input int ch, input int d);
    cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_div = W'(d);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Assumes reset just released with ch0 enabled in toggle mode.
  task automatic measure();
    int rise = -1, fall = -1, rise2 = -1;
    logic prev;
    prev = clk_out[0];
    for (int k = 1; k <= 90; k++) begin
      cycle();
      if (!prev && clk_out[0]) begin
        if (rise < 0) rise = k; else if (rise2 < 0) rise2 = k;
      end
      if (prev && !clk_out[0] && rise >= 0 && fall < 0) fall = k;
      prev = clk_out[0];
    end
    check("first_rise", rise, 25);
    check("high_len", fall - rise, 25);
    check("period", rise2 - rise, 50);
  endtask

  initial begin
    int ticks;
    rst = 1'b1; en = '0; mode = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    @(posedge clk_in);
    model();
    @(negedge clk_in);
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_pending", pending, 0);
    check("rst_ready", cfg_ready, 1);
    rst = 1'b0; en = 2'b11;
    measure();
    mode[1] = 1'b1;
    write(1, 3);
    for (int k = 0; k < 40 && pd[1]; k++) cycle();
    check("ch1_applied", pending[1], 0);
    ticks = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      ticks += int'(tick[1]) + int'(clk_out[1]);
    end
    check("ch1_pulses", ticks, 8);
    mode = '0;
    do_reset();
    run(10);
    write(0, 4);
    check("ch0_pending", pending[0], 1);
    cfg_ch = 1'b0;
    #1 check("ch0_not_ready", cfg_ready, 0);
    run(60);
    write(0, 0);
    run(30);
    write(0, 3);
    write(1, 3);
    run(37);
    sync = 1'b1; cycle(); sync = 1'b0;
    check("sync_out", clk_out, 0);
    run(20);
    en = 2'b10;
    write(1, 5);
    run(3);
    do_reset();
    en = 2'b11;
    measure();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      sync = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) == 0) ? N'($urandom) : 2'b11;
      mode = N'($urandom);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ch = 1'($urandom);
      cfg_div = W'($urandom_range(0, 9));
      cycle();
    end
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
